// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, field and fetch-state definitions
//
// Purpose: constants and types shared by the fetch sequencer and the
//          control unit. Opcode field positions, the flow-control opcodes
//          handled inside the fetch unit, and the fetch FSM state encoding.
// Ports:   none (package).
package cpu_pkg;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_JMP = 5'd16;
  localparam logic [4:0] OP_HLT = 5'd31;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 27;
  localparam int JMP_TGT_MSB = 26;
  localparam int JMP_TGT_LSB = 19;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  function automatic logic [4:0] opc_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer with local JMP/HLT execution
//
// Purpose: walks the program counter through a synchronous-read instruction
//          memory and presents each fetched datapath word on op_code for one
//          clock (zeros otherwise). HLT stops fetching; JMP (when the
//          FETCH_JUMP_EN macro is defined) reloads the PC without emitting.
// Config:  `define FETCH_JUMP_EN to execute opcode 16 as JMP; otherwise it is
//          forwarded like any other word.
// Ports:   clk, rst_n      - clock, asynchronous active-low reset
//          start           - begin execution at RESET_PC from IDLE or HALT
//          stall           - hold the fetch in REQ
//          imem_rd         - memory read strobe (combinational, REQ only)
//          imem_addr       - memory read address (= pc)
//          imem_data       - read data, valid the cycle after imem_rd
//          op_code         - instruction to the control unit, 0 when not valid
//          op_valid        - one-cycle qualifier for op_code
//          pc              - current program counter
//          halted          - high while in HALT
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       op_code,
  output logic              op_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_t state;
  logic [4:0]   opc;

  assign opc       = opc_of(imem_data);
  assign imem_rd   = (state == S_REQ) && !stall;
  assign imem_addr = pc;

`ifdef FETCH_JUMP_EN
  logic [ADDR_W-1:0] jmp_tgt;
  // Target field is 8 bits wide; the cast zero-extends or truncates to ADDR_W.
  assign jmp_tgt = ADDR_W'(imem_data[JMP_TGT_MSB:JMP_TGT_LSB]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      op_code  <= '0;
      op_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      // Output is a single-cycle pulse; only a forwarding WAIT edge raises it.
      op_code  <= '0;
      op_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= RESET_PC;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!stall) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (opc == OP_HLT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end
`ifdef FETCH_JUMP_EN
          else if (opc == OP_JMP) begin
            pc    <= jmp_tgt;
            state <= S_REQ;
          end
`endif
          else begin
            op_code  <= imem_data;
            op_valid <= 1'b1;
            pc       <= pc + ADDR_W'(1);
            state    <= S_REQ;
          end
        end
        S_HALT: begin
          if (start) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            state  <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

  localparam int ADDR_W = 4;
  localparam logic [31:0] HLT_W = 32'hF800_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stall;
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data = '0;
  logic [31:0]       op_code;
  logic              op_valid;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  logic [31:0] mem [16];

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (4'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .imem_rd   (imem_rd),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .op_code   (op_code),
    .op_valid  (op_valid),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid output must match the head of the scoreboard,
  // in content and in cycle; idle cycles must carry a zero op_code.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (op_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_op: got op_code %h at cycle %0d, expected no output", op_code, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("op_code", op_code, e.data);
          check("op_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_op_code", op_code, 32'h0);
      end
    end
  end

  // Pulse start for one edge; returns just after that edge with cyc == s.
  task automatic go(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic at_cycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic wait_halt();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("halt_reached", {31'b0, halted}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = HLT_W;
    repeat (2) @(negedge clk);
    check("rst_op_code", op_code, 32'h0);
    check("rst_op_valid", {31'b0, op_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_imem_rd", {31'b0, imem_rd}, 32'h0);
    check("rst_pc", {28'b0, pc}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_rd", {31'b0, imem_rd}, 32'h0);

    // Two forwarded words then HLT
    mem[0] = 32'h1000_0000;
    mem[1] = 32'h8888_0000;
    mem[2] = HLT_W;
    go(s);
    sb.push_back('{s + 2, 32'h1000_0000});
    sb.push_back('{s + 4, 32'h8888_0000});
    wait_halt();
    check("halt_pc", {28'b0, pc}, 32'd2);
    repeat (3) begin
      @(negedge clk);
      check("halt_no_rd", {31'b0, imem_rd}, 32'h0);
    end

    // Restart from HALT resumes at RESET_PC
    go(s);
    sb.push_back('{s + 2, 32'h1000_0000});
    sb.push_back('{s + 4, 32'h8888_0000});
    at_cycle(s);
    check("restart_rd", {31'b0, imem_rd}, 32'h1);
    check("restart_addr", {28'b0, imem_addr}, 32'h0);
    check("restart_halted", {31'b0, halted}, 32'h0);
    wait_halt();

    // Stall held for 4 REQ cycles delays the word by exactly 4
    mem[0] = 32'h0000_0123;
    mem[1] = HLT_W;
    @(negedge clk);
    start = 1'b1;
    stall = 1'b1;
    s = cyc + 1;
    sb.push_back('{s + 6, 32'h0000_0123});
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_no_rd", {31'b0, imem_rd}, 32'h0);
    end
    @(posedge clk);
    #1 stall = 1'b0;
    wait_halt();
    check("stall_pc", {28'b0, pc}, 32'd1);

`ifdef FETCH_JUMP_EN
    mem[0] = 32'h8028_0000;
    mem[5] = 32'h0800_0000;
    mem[6] = HLT_W;
    go(s);
    sb.push_back('{s + 4, 32'h0800_0000});
    at_cycle(s + 2);
    check("jmp_addr", {28'b0, imem_addr}, 32'd5);
    check("jmp_rd", {31'b0, imem_rd}, 32'h1);
    wait_halt();
    check("jmp_pc", {28'b0, pc}, 32'd6);
`else
    mem[0] = 32'h8028_0000;
    mem[1] = HLT_W;
    go(s);
    sb.push_back('{s + 2, 32'h8028_0000});
    wait_halt();
    check("op16_pc", {28'b0, pc}, 32'd1);
`endif

    // PC wrap 15 -> 0 on a forwarded word
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_1000 + i;
    go(s);
    for (int i = 0; i < 16; i++) sb.push_back('{s + 2 + 2 * i, 32'h0000_1000 + i});
    at_cycle(s + 2);
    mem[0] = HLT_W;
    at_cycle(s + 31);
    check("wrap_pc15", {28'b0, pc}, 32'd15);
    at_cycle(s + 32);
    check("wrap_pc0", {28'b0, pc}, 32'd0);
    check("wrap_addr0", {28'b0, imem_addr}, 32'd0);
    check("wrap_rd", {31'b0, imem_rd}, 32'h1);
    wait_halt();

    // Reset during WAIT discards the in-flight word
    mem[0] = 32'h0000_0555;
    mem[1] = 32'h0000_0777;
    go(s);
    sb.push_back('{s + 2, 32'h0000_0555});
    at_cycle(s + 3);
    check("pre_rst_pc", {28'b0, pc}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("wrst_op_code", op_code, 32'h0);
    check("wrst_op_valid", {31'b0, op_valid}, 32'h0);
    check("wrst_pc", {28'b0, pc}, 32'h0);
    check("wrst_imem_rd", {31'b0, imem_rd}, 32'h0);
    check("wrst_halted", {31'b0, halted}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_idle", {31'b0, imem_rd}, 32'h0);
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that produces the 32-bit `op_code` stream consumed by the processor's control unit. It walks a program counter through a synchronous-read instruction memory and presents each fetched word on `op_code` for exactly one clock, with NOP (all zeros) in every other cycle. It also executes the flow-control opcodes JMP and HLT locally, so the decoder only ever sees datapath instructions.

## Interface
- `ADDR_W`, default 8: instruction memory address width.
- `RESET_PC`, default 0: program entry address loaded on reset and on `start`.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level-sampled; begins execution from `RESET_PC` when in IDLE or HALT.
- `stall`  in  1: holds the fetch in REQ while high.
- `imem_rd`  out  1: memory read strobe.
- `imem_addr`  out  ADDR_W: memory read address.
- `imem_data`  in  32: read data, valid the cycle after `imem_rd`.
- `op_code`  out  32: instruction to the control unit; 32'h0 when not valid.
- `op_valid`  out  1: high for the one cycle `op_code` carries a fetched instruction.
- `pc`  out  ADDR_W: current program counter.
- `halted`  out  1: high in HALT.

## Operation
- Opcode field is `[31:27]`. Opcodes 0–15 are forwarded unchanged. 16 = JMP, with target in `[26:19]`, zero-extended or truncated to ADDR_W. 31 = HLT. Opcodes 17–30 are forwarded unchanged.
- States: IDLE, REQ, WAIT, HALT.
- **IDLE:** `imem_rd`=0. When `start`=1: `pc`<=RESET_PC, go to REQ.
- **REQ:** `imem_rd`=!stall and `imem_addr`=pc, both combinational. If stall=1, stay in REQ. Otherwise go to WAIT.
- **WAIT:** `imem_data` is valid. At the clock edge, decode as follows:
  - HLT: `op_code` stays 0, `pc` unchanged, go to HALT.
  - JMP: `op_code` stays 0, `pc`<=target, go to REQ.
  - Otherwise: `op_code`<=imem_data, `op_valid`<=1, `pc`<=pc+1 (mod 2^ADDR_W), go to REQ.
- `op_code` and `op_valid` are registered. In every cycle not immediately following a forwarding WAIT edge they are 0, so the decoder never executes a word twice.
- `stall` is ignored outside REQ. A WAIT capture always completes.
- **HALT:** `halted`=1. `start`=1 reloads RESET_PC, clears `halted`, and goes to REQ.
- `start` is ignored in REQ and WAIT.
- Reset values: state IDLE, `pc`=RESET_PC, `op_code`=0, `op_valid`=0, `halted`=0, `imem_rd`=0.
- Reset asserted mid-fetch aborts immediately. A word in flight is discarded.

## Timing
- Throughput: one instruction per 2 cycles with no stall.
- Latency: `imem_rd` in cycle n, then `op_code`/`op_valid` valid in cycle n+2.
- First instruction after `start`:
  - `start` sampled at edge 0.
  - REQ in cycle 1.
  - WAIT in cycle 2.
  - `op_valid` in cycle 3.
- JMP costs 2 cycles with no output. The target's REQ follows directly.
- PC wrap: `pc`=2^ADDR_W−1 forwarding → `pc`=0.
- JMP to own address loops indefinitely. This is legal.

## Configuration
- `FETCH_JUMP_EN`
  - Defined: opcode 16 is executed as JMP as above.
  - Undefined: opcode 16 is forwarded like any other word and `pc` increments. HLT is always supported.

## Structure
- Shared package `cpu_pkg`:
  - `OP_NOP`=5'd0, `OP_JMP`=5'd16, `OP_HLT`=5'd31.
  - Field positions `OPC_MSB`=31, `OPC_LSB`=27, `JMP_TGT_MSB`=26, `JMP_TGT_LSB`=19.
  - Fetch state encoding.
- Single module, no sub-module; the PC counter and FSM are too small to split.

## Test plan
- Reset, then `start`; memory [0]=32'h10000000, [1]=32'h88880000. → `op_code`=32'h10000000 in cycle 3, 32'h88880000 in cycle 5, zeros in cycles 4 and 6; `pc`=2 after.
- Memory [2]=HLT (32'hF8000000). → no `op_valid` for it, `halted`=1, `imem_rd` stays 0. `start` → fetch resumes at RESET_PC.
- `FETCH_JUMP_EN`, memory [0]=32'h80280000 (JMP 5), [5]=32'h08000000. → no output for JMP; `imem_addr`=5 in cycle 3; `op_code`=32'h08000000 in cycle 5.
- `stall` held 4 cycles in REQ. → `imem_rd`=0 throughout; instruction appears exactly 4 cycles late with no duplicate.
- ADDR_W=4, `pc`=15, non-flow word. → `pc`=0 next, `imem_addr`=0.
- `rst_n` low in WAIT. → `op_code`=0, `op_valid`=0, IDLE, `pc`=RESET_PC; fetched word never appears.
